// File: rtl/vga_board_arbiter.sv
// vga_board_arbiter
// Shares the single-port tic-tac-toe board RAM between the VGA renderer,
// the game FSM and a board-clear engine. The renderer owns the port during
// active display. Clear writes and game-logic accesses are fitted into
// blanking cycles.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   disp_active             high during active display (renderer owns RAM)
//   pix_addr                renderer cell index
//   pix_data, pix_valid     renderer read data, one cycle after pix_addr
//   gl_req/we/addr/wdata    game-logic request, held until gl_ack
//   gl_ack                  grant pulse (combinational)
//   gl_rdata, gl_rvalid     game read data, one cycle after a read grant
//   clear_req               start a board clear (sampled in IDLE)
//   busy, clear_done        clear in progress / one-cycle completion pulse
//   ram_addr/we/wdata       RAM port (combinational)
//   ram_rdata               RAM read data, one cycle after address
module vga_board_arbiter #(
  parameter int CELLS  = 9,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [DATA_W-1:0] gl_wdata,
  output logic              gl_ack,
  output logic [DATA_W-1:0] gl_rdata,
  output logic              gl_rvalid,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              pix_valid_q, pix_valid_d;
  logic              gl_rvalid_q, gl_rvalid_d;
  logic              rd_oor_q, rd_oor_d;
  logic              clear_done_q, clear_done_d;
  logic              busy_q, busy_d;

  logic              last_cell_s;
  logic              gl_in_range_s;

  assign last_cell_s   = (clr_idx_q == ADDR_W'(CELLS - 1));
  // Widen by one bit so the comparison also holds when CELLS == 2**ADDR_W.
  assign gl_in_range_s = ({1'b0, gl_addr} < (ADDR_W + 1)'(CELLS));

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clr_idx_q    <= '0;
      pix_valid_q  <= 1'b0;
      gl_rvalid_q  <= 1'b0;
      rd_oor_q     <= 1'b0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      pix_valid_q  <= pix_valid_d;
      gl_rvalid_q  <= gl_rvalid_d;
      rd_oor_q     <= rd_oor_d;
      clear_done_q <= clear_done_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic: display time freezes the clear engine at its index.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (reset) begin
      state_d   = ST_IDLE;
      clr_idx_d = '0;
    end else if (disp_active) begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (last_cell_s) begin
            state_d   = ST_IDLE;
            clr_idx_d = '0;
          end else begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end
      endcase
    end
  end

  // Port ownership, grant and next values of the registered outputs.
  always_comb begin
    ram_addr     = '0;
    ram_we       = 1'b0;
    ram_wdata    = '0;
    gl_ack       = 1'b0;
    clear_done_d = 1'b0;
    rd_oor_d     = 1'b0;
    if (reset) begin
      ram_we = 1'b0;
    end else if (disp_active) begin
      ram_addr = pix_addr;
    end else if (state_q == ST_CLEAR) begin
      ram_addr     = clr_idx_q;
      ram_we       = 1'b1;
      clear_done_d = last_cell_s;
    end else if (clear_req) begin
      // Clear accepted this cycle; the port stays idle.
      ram_we = 1'b0;
    end else if (gl_req) begin
      gl_ack    = 1'b1;
      ram_addr  = gl_addr;
      ram_we    = gl_we & gl_in_range_s;
      ram_wdata = gl_wdata;
      rd_oor_d  = ~gl_in_range_s;
    end else begin
      ram_we = 1'b0;
    end
    pix_valid_d = disp_active & ~reset;
    gl_rvalid_d = gl_ack & ~gl_we;
    busy_d      = (state_d == ST_CLEAR);
  end

  assign pix_valid  = pix_valid_q;
  assign gl_rvalid  = gl_rvalid_q;
  assign clear_done = clear_done_q;
  assign busy       = busy_q;
  assign pix_data   = pix_valid_q ? ram_rdata : '0;
  assign gl_rdata   = (gl_rvalid_q && !rd_oor_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_vga_board_arbiter.sv
module tb_vga_board_arbiter;
  localparam int CELLS  = 9;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 2;

  logic              clk;
  logic              reset;
  logic              disp_active;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              gl_req;
  logic              gl_we;
  logic [ADDR_W-1:0] gl_addr;
  logic [DATA_W-1:0] gl_wdata;
  logic              gl_ack;
  logic [DATA_W-1:0] gl_rdata;
  logic              gl_rvalid;
  logic              clear_req;
  logic              busy;
  logic              clear_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int errors = 0;
  int checks = 0;

  // Board RAM model: synchronous write, one-cycle registered read.
  logic [DATA_W-1:0] mem [0:15];
  logic              load_en;
  logic [17:0]       load_pat;

  vga_board_arbiter #(.CELLS(CELLS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .disp_active(disp_active), .pix_addr(pix_addr),
    .pix_data(pix_data), .pix_valid(pix_valid), .gl_req(gl_req), .gl_we(gl_we),
    .gl_addr(gl_addr), .gl_wdata(gl_wdata), .gl_ack(gl_ack), .gl_rdata(gl_rdata),
    .gl_rvalid(gl_rvalid), .clear_req(clear_req), .busy(busy),
    .clear_done(clear_done), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with a bulk-load path used to preload the board.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= (i < CELLS) ? load_pat[2*i +: 2] : 2'd3;
      end
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_board(input logic [17:0] pat);
    load_pat = pat;
    load_en  = 1'b1;
    cyc();
    load_en  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; disp_active = 1'b0; gl_req = 1'b1; gl_we = 1'b1;
    gl_addr = 4'd2; gl_wdata = 2'd1; clear_req = 1'b0; pix_addr = 4'd0;
    load_en = 1'b0; load_pat = 18'd0;
    cyc(); cyc();
    @(negedge clk);
    checks++; if (gl_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", gl_ack); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", ram_we); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %b exp 0", pix_valid); end
    checks++; if (gl_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", gl_rvalid); end
    checks++; if (busy !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, clear_done); end
    checks++; if (pix_data !== 2'd0 || gl_rdata !== 2'd0) begin errors++; $display("FAIL reset_data got %0d/%0d exp 0/0", pix_data, gl_rdata); end
    cyc();
    reset = 1'b0; gl_req = 1'b0; gl_we = 1'b0;
    cyc();
  endtask

  task automatic test_render();
    logic [17:0] pat;
    logic [1:0]  exp;
    for (int i = 0; i < CELLS; i++) pat[2*i +: 2] = 2'(i % 3);
    load_board(pat);
    gl_req = 1'b1; gl_we = 1'b0; gl_addr = 4'd0;
    for (int i = 0; i <= CELLS; i++) begin
      if (i < CELLS) begin
        disp_active = 1'b1; pix_addr = 4'(i);
      end else begin
        disp_active = 1'b0; gl_req = 1'b0; pix_addr = 4'd0;
      end
      @(negedge clk);
      if (i < CELLS) begin
        checks++; if (gl_ack !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL render_no_ack i=%0d got ack=%b we=%b exp 0 0", i, gl_ack, ram_we); end
        checks++; if (ram_addr !== 4'(i)) begin errors++; $display("FAIL render_addr got %0d exp %0d", ram_addr, i); end
      end
      checks++; if (pix_valid !== (i > 0)) begin errors++; $display("FAIL render_valid i=%0d got %b exp %b", i, pix_valid, (i > 0)); end
      if (i > 0) begin
        exp = 2'((i - 1) % 3);
        checks++; if (pix_data !== exp) begin errors++; $display("FAIL render_data i=%0d got %0d exp %0d", i, pix_data, exp); end
      end
      cyc();
    end
    @(negedge clk);
    checks++; if (pix_valid !== 1'b0 || pix_data !== 2'd0) begin errors++; $display("FAIL render_end got v=%b d=%0d exp 0 0", pix_valid, pix_data); end
    cyc();
  endtask

  task automatic test_back_to_back();
    disp_active = 1'b0;
    gl_req = 1'b1; gl_we = 1'b1; gl_addr = 4'd4; gl_wdata = 2'd2;
    @(negedge clk);
    checks++; if (gl_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'd4 || ram_wdata !== 2'd2) begin
      errors++; $display("FAIL b2b_write got ack=%b we=%b a=%0d d=%0d exp 1 1 4 2", gl_ack, ram_we, ram_addr, ram_wdata); end
    cyc();
    gl_we = 1'b0;
    @(negedge clk);
    checks++; if (gl_ack !== 1'b1 || ram_we !== 1'b0 || gl_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_read_ack got ack=%b we=%b rv=%b exp 1 0 0", gl_ack, ram_we, gl_rvalid); end
    cyc();
    gl_req = 1'b0;
    @(negedge clk);
    checks++; if (gl_rvalid !== 1'b1 || gl_rdata !== 2'd2 || gl_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_rdata got rv=%b d=%0d ack=%b exp 1 2 0", gl_rvalid, gl_rdata, gl_ack); end
    cyc();
    @(negedge clk);
    checks++; if (gl_rvalid !== 1'b0 || gl_rdata !== 2'd0) begin errors++; $display("FAIL b2b_rvalid_drop got rv=%b d=%0d exp 0 0", gl_rvalid, gl_rdata); end
    cyc();
  endtask

  task automatic test_display_wait();
    int acks = 0;
    int writes = 0;
    gl_req = 1'b1; gl_we = 1'b1; gl_addr = 4'd1; gl_wdata = 2'd2;
    disp_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gl_ack) acks++;
      if (ram_we) writes++;
      cyc();
    end
    disp_active = 1'b0;
    @(negedge clk);
    checks++; if (gl_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'd1) begin
      errors++; $display("FAIL wait_first_blank got ack=%b we=%b a=%0d exp 1 1 1", gl_ack, ram_we, ram_addr); end
    if (ram_we) writes++;
    cyc();
    gl_req = 1'b0; gl_we = 1'b0;
    @(negedge clk);
    checks++; if (acks !== 0) begin errors++; $display("FAIL wait_display_acks got %0d exp 0", acks); end
    checks++; if (writes !== 1) begin errors++; $display("FAIL wait_ram_accesses got %0d exp 1", writes); end
    checks++; if (mem[1] !== 2'd2) begin errors++; $display("FAIL wait_mem got %0d exp 2", mem[1]); end
    cyc();
  endtask

  task automatic test_clear();
    int  nw = 0;
    bit  done = 1'b0;
    load_board({9{2'b01}});
    disp_active = 1'b0; clear_req = 1'b1; gl_req = 1'b1; gl_we = 1'b0; gl_addr = 4'd3;
    @(negedge clk);
    checks++; if (gl_ack !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_accept got ack=%b we=%b busy=%b exp 0 0 0", gl_ack, ram_we, busy); end
    cyc();
    gl_req = 1'b0;
    for (int p = 0; p < 60 && !done; p++) begin
      disp_active = ((p % 5) < 3);
      clear_req   = (p < 5);
      @(negedge clk);
      checks++; if (busy !== (nw < 9)) begin errors++; $display("FAIL clear_busy p=%0d got %b exp %b", p, busy, (nw < 9)); end
      checks++; if (clear_done !== (nw == 9)) begin errors++; $display("FAIL clear_done p=%0d got %b exp %b", p, clear_done, (nw == 9)); end
      if (nw == 9) done = 1'b1;
      if (ram_we) begin
        checks++; if (disp_active !== 1'b0 || ram_addr !== 4'(nw) || ram_wdata !== 2'd0) begin
          errors++; $display("FAIL clear_write got disp=%b a=%0d d=%0d exp 0 %0d 0", disp_active, ram_addr, ram_wdata, nw); end
        nw++;
      end
      cyc();
    end
    checks++; if (!done) begin errors++; $display("FAIL clear_timeout got writes=%0d exp 9", nw); end
    disp_active = 1'b0; clear_req = 1'b0;
    @(negedge clk);
    checks++; if (clear_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_single_pulse got done=%b busy=%b exp 0 0", clear_done, busy); end
    for (int i = 0; i <= CELLS; i++) begin
      if (i < CELLS) begin gl_req = 1'b1; gl_addr = 4'(i); end else gl_req = 1'b0;
      @(negedge clk);
      if (i < CELLS) begin
        checks++; if (gl_ack !== 1'b1) begin errors++; $display("FAIL clear_read_ack i=%0d got %b exp 1", i, gl_ack); end
      end
      if (i > 0) begin
        checks++; if (gl_rvalid !== 1'b1 || gl_rdata !== 2'd0) begin errors++; $display("FAIL clear_read i=%0d got rv=%b d=%0d exp 1 0", i - 1, gl_rvalid, gl_rdata); end
      end
      cyc();
    end
  endtask

  task automatic test_out_of_range();
    disp_active = 1'b0; gl_req = 1'b1; gl_we = 1'b0; gl_addr = 4'd12;
    @(negedge clk);
    checks++; if (gl_ack !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL oor_read_ack got ack=%b we=%b exp 1 0", gl_ack, ram_we); end
    cyc();
    gl_req = 1'b0;
    @(negedge clk);
    checks++; if (gl_rvalid !== 1'b1 || gl_rdata !== 2'd0) begin errors++; $display("FAIL oor_rdata got rv=%b d=%0d exp 1 0", gl_rvalid, gl_rdata); end
    cyc();
    gl_req = 1'b1; gl_we = 1'b1; gl_addr = 4'd9; gl_wdata = 2'd2;
    @(negedge clk);
    checks++; if (gl_ack !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL oor_write got ack=%b we=%b exp 1 0", gl_ack, ram_we); end
    cyc();
    gl_req = 1'b0; gl_we = 1'b0;
    @(negedge clk);
    checks++; if (mem[9] !== 2'd3) begin errors++; $display("FAIL oor_mem got %0d exp 3", mem[9]); end
    cyc();
  endtask

  task automatic test_reset_mid_clear();
    bit done = 1'b0;
    load_board({9{2'b11}});
    disp_active = 1'b0; clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (ram_we !== 1'b1 || ram_addr !== 4'(k)) begin errors++; $display("FAIL mid_write got we=%b a=%0d exp 1 %0d", ram_we, ram_addr, k); end
      cyc();
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_reset_we got %b exp 0", ram_we); end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL mid_after_reset got busy=%b done=%b exp 0 0", busy, clear_done); end
    cyc();
    @(negedge clk);
    checks++; if (clear_done !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL mid_no_done got done=%b we=%b exp 0 0", clear_done, ram_we); end
    checks++; if (mem[3] !== 2'd0 || mem[4] !== 2'd3) begin errors++; $display("FAIL mid_cells got m3=%0d m4=%0d exp 0 3", mem[3], mem[4]); end
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    for (int k = 0; k < CELLS; k++) begin
      @(negedge clk);
      checks++; if (ram_we !== 1'b1 || ram_addr !== 4'(k)) begin errors++; $display("FAIL restart_write got we=%b a=%0d exp 1 %0d", ram_we, ram_addr, k); end
      cyc();
    end
    @(negedge clk);
    checks++; if (clear_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL restart_done got done=%b busy=%b exp 1 0", clear_done, busy); end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_render();
    test_back_to_back();
    test_display_wait();
    test_clear();
    test_out_of_range();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
